// File: rtl/keypad_entry.sv
// 4x4 matrix keypad scanner: walks an active-low column select, debounces the
// synchronized rows and shifts each accepted key code into a 16-bit entry register.
module keypad_entry #(
   parameter int SCAN_DIV = 100000,
   parameter int DEBOUNCE = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  kb_row,
   output logic [3:0]  kb_col,
   output logic        key_valid,
   output logic [3:0]  key_code,
   output logic [15:0] data,
   output logic [1:0]  dbg_state
);

   localparam int         DIV_W   = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam logic [3:0] CNT_MAX = 4'(DEBOUNCE);

   typedef enum logic [1:0] {
      ST_SCAN     = 2'd0,
      ST_DEBOUNCE = 2'd1,
      ST_HOLD     = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [3:0]         r_row_s1;
   logic [3:0]         r_row_s2;
   logic [DIV_W-1:0]   r_div;
   logic [3:0]         r_kb_col;
   logic [3:0]         w_kb_col_nxt;
   logic [3:0]         w_kb_col_rot;
   logic [3:0]         r_cnt;
   logic [3:0]         w_cnt_nxt;
   logic [3:0]         w_cnt_inc;
   logic [1:0]         r_row_idx;
   logic [1:0]         w_row_idx_nxt;
   logic [1:0]         r_col_idx;
   logic [1:0]         w_col_idx_nxt;
   logic               r_key_valid;
   logic [3:0]         r_key_code;
   logic [15:0]        r_data;
   logic               w_tick;
   logic               w_row_any;
   logic [1:0]         w_row_idx;
   logic [1:0]         w_col_idx;
   logic               w_accept;

   // Two-flop synchronizer; the raw rows are never used past this point.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_row_s1 <= 4'b1111;
         r_row_s2 <= 4'b1111;
      end else begin
         r_row_s1 <= kb_row;
         r_row_s2 <= r_row_s1;
      end
   end

   assign w_tick = (r_div == DIV_W'(SCAN_DIV - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_div <= '0;
      end else if (w_tick) begin
         r_div <= '0;
      end else begin
         r_div <= r_div + DIV_W'(1);
      end
   end

   assign w_row_any    = (r_row_s2 != 4'b1111);
   assign w_kb_col_rot = {r_kb_col[2:0], r_kb_col[3]};
   assign w_cnt_inc    = r_cnt + 4'd1;

   // Lowest-index low row wins when several rows are pulled low together.
   always_comb begin
      w_row_idx = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (!r_row_s2[i]) begin
            w_row_idx = 2'(i);
         end
      end
   end

   always_comb begin
      w_col_idx = 2'd0;
      case (r_kb_col)
         4'b1110: w_col_idx = 2'd0;
         4'b1101: w_col_idx = 2'd1;
         4'b1011: w_col_idx = 2'd2;
         4'b0111: w_col_idx = 2'd3;
         default: w_col_idx = 2'd0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_SCAN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // The same counter serves as press count in DEBOUNCE and release count in HOLD.
   always_comb begin
      w_state_nxt   = r_state;
      w_kb_col_nxt  = r_kb_col;
      w_cnt_nxt     = r_cnt;
      w_row_idx_nxt = r_row_idx;
      w_col_idx_nxt = r_col_idx;
      w_accept      = 1'b0;
      if (w_tick) begin
         case (r_state)
            ST_SCAN: begin
               if (!w_row_any) begin
                  w_kb_col_nxt = w_kb_col_rot;
               end else begin
                  w_row_idx_nxt = w_row_idx;
                  w_col_idx_nxt = w_col_idx;
                  w_cnt_nxt     = 4'd1;
                  w_state_nxt   = ST_DEBOUNCE;
               end
            end
            ST_DEBOUNCE: begin
               if (w_row_any && (w_row_idx == r_row_idx)) begin
                  if (w_cnt_inc == CNT_MAX) begin
                     w_accept    = 1'b1;
                     w_cnt_nxt   = 4'd0;
                     w_state_nxt = ST_HOLD;
                  end else begin
                     w_cnt_nxt = w_cnt_inc;
                  end
               end else begin
                  w_cnt_nxt    = 4'd0;
                  w_kb_col_nxt = w_kb_col_rot;
                  w_state_nxt  = ST_SCAN;
               end
            end
            ST_HOLD: begin
               if (w_row_any) begin
                  w_cnt_nxt = 4'd0;
               end else if (w_cnt_inc == CNT_MAX) begin
                  w_cnt_nxt    = 4'd0;
                  w_kb_col_nxt = w_kb_col_rot;
                  w_state_nxt  = ST_SCAN;
               end else begin
                  w_cnt_nxt = w_cnt_inc;
               end
            end
            default: begin
               w_cnt_nxt    = 4'd0;
               w_kb_col_nxt = 4'b1110;
               w_state_nxt  = ST_SCAN;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_kb_col  <= 4'b1110;
         r_cnt     <= 4'd0;
         r_row_idx <= 2'd0;
         r_col_idx <= 2'd0;
      end else begin
         r_kb_col  <= w_kb_col_nxt;
         r_cnt     <= w_cnt_nxt;
         r_row_idx <= w_row_idx_nxt;
         r_col_idx <= w_col_idx_nxt;
      end
   end

   // key_valid is a bare one-clk strobe: there is no ready, the consumer must sample it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_key_valid <= 1'b0;
         r_key_code  <= 4'h0;
         r_data      <= 16'h0000;
      end else begin
         r_key_valid <= w_accept;
         if (w_accept) begin
            r_key_code <= {r_row_idx, r_col_idx};
            r_data     <= {r_data[11:0], r_row_idx, r_col_idx};
         end
      end
   end

   assign kb_col    = r_kb_col;
   assign key_valid = r_key_valid;
   assign key_code  = r_key_code;
   assign data      = r_data;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_keypad_entry.sv
// Bench for keypad_entry: a keypad switch-matrix model drives the rows, a monitor
// scores every key_valid against expected codes and the last four entered digits.
module tb_keypad_entry;

   localparam int SCAN_DIV = 4;
   localparam int DEBOUNCE = 3;

   logic        clk;
   logic        rst_n;
   logic [3:0]  kb_row;
   logic [3:0]  kb_col;
   logic        key_valid;
   logic [3:0]  key_code;
   logic [15:0] data;
   logic [1:0]  dbg_state;

   logic [15:0] pressed;
   logic        ovr_en;
   logic [3:0]  ovr_val;
   logic [3:0]  key_rows;
   logic [3:0]  exp_q[$];
   logic [3:0]  digit_q[$];
   logic [3:0]  mon_exp;
   logic        prev_valid;
   int          n_checks;
   int          n_errors;
   int          n_pulses;

   keypad_entry #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .kb_row    (kb_row),
      .kb_col    (kb_col),
      .key_valid (key_valid),
      .key_code  (key_code),
      .data      (data),
      .dbg_state (dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500us;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Switch matrix: key r*4+c pulls row r low while column c is selected.
   always_comb begin
      key_rows = 4'b1111;
      for (int k = 0; k < 16; k++) begin
         if (pressed[k] && !kb_col[k % 4]) key_rows[k / 4] = 1'b0;
      end
      kb_row = ovr_en ? ovr_val : key_rows;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Display content is simply the last four digits entered since reset.
   function automatic logic [15:0] exp_data();
      logic [15:0] d;
      d = 16'h0000;
      foreach (digit_q[i]) d = {d[11:0], digit_q[i]};
      return d;
   endfunction

   function automatic logic [3:0] col_pat(input int idx);
      logic [3:0] p;
      p = 4'b1111;
      p[idx % 4] = 1'b0;
      return p;
   endfunction

   always @(negedge clk) begin
      if (rst_n) begin
         check("col_onehot", 32'($countones(~kb_col)), 32'd1);
         if (key_valid) begin
            n_pulses++;
            check("valid_single", 32'(prev_valid), 32'd0);
            if (exp_q.size() == 0) begin
               check("unexpected_valid", 32'd1, 32'd0);
            end else begin
               mon_exp = exp_q.pop_front();
               check("key_code", 32'(key_code), 32'(mon_exp));
               digit_q.push_back(mon_exp);
               check("data", 32'(data), 32'(exp_data()));
            end
         end
      end
      prev_valid = key_valid;
   end

   task automatic wait_pulse(input int base, input int limit, output bit seen);
      seen = 1'b0;
      for (int i = 0; i < limit && !seen; i++) begin
         @(negedge clk);
         if (n_pulses > base) seen = 1'b1;
      end
   endtask

   task automatic press_key(input int k, input int hold);
      int base;
      bit seen;
      base = n_pulses;
      exp_q.push_back(4'(k));
      pressed[k] = 1'b1;
      wait_pulse(base, 200, seen);
      check("press_seen", 32'(seen), 32'd1);
      if (!seen) void'(exp_q.pop_back());
      repeat (hold) @(negedge clk);
      pressed = '0;
      repeat (6 * SCAN_DIV) @(negedge clk);
   endtask

   // Waits for the scan to step onto column idx; the step itself marks a tick edge.
   task automatic wait_col_step(input int idx, output bit found);
      logic [3:0] prev;
      found = 1'b0;
      prev = kb_col;
      for (int i = 0; i < 80 && !found; i++) begin
         @(negedge clk);
         if (kb_col != prev && kb_col == col_pat(idx)) found = 1'b1;
         prev = kb_col;
      end
      check("col_step_seen", 32'(found), 32'd1);
   endtask

   // After reset release the divider starts at 0, so the column steps every SCAN_DIV clks.
   task automatic check_rotation();
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("rotation", 32'(kb_col), 32'(col_pat((i + 1) / SCAN_DIV)));
      end
   endtask

   // Rows forced low right after a tick: detection at the next tick, acceptance DEBOUNCE-1 ticks later.
   task automatic latency_test(input int col, input logic [3:0] rows, input logic [3:0] code);
      bit found;
      wait_col_step(col, found);
      if (found) begin
         exp_q.push_back(code);
         ovr_val = rows;
         ovr_en  = 1'b1;
         for (int k = 1; k <= DEBOUNCE * SCAN_DIV + 1; k++) begin
            @(negedge clk);
            if (k == DEBOUNCE * SCAN_DIV - 1) check("lat_before", 32'(key_valid), 32'd0);
            if (k == DEBOUNCE * SCAN_DIV)     check("lat_pulse", 32'(key_valid), 32'd1);
            if (k == DEBOUNCE * SCAN_DIV + 1) check("lat_after", 32'(key_valid), 32'd0);
         end
         repeat (8) @(negedge clk);
         check("lat_col_held", 32'(kb_col), 32'(col_pat(col)));
         ovr_en  = 1'b0;
         ovr_val = 4'b1111;
         repeat (6 * SCAN_DIV) @(negedge clk);
      end
   endtask

   initial begin
      bit found;
      int base;
      logic [3:0] c0;
      n_checks   = 0;
      n_errors   = 0;
      n_pulses   = 0;
      prev_valid = 1'b0;
      pressed    = '0;
      ovr_en     = 1'b0;
      ovr_val    = 4'b1111;
      rst_n      = 1'b0;

      repeat (3) @(negedge clk);
      check("rst_col", 32'(kb_col), 32'h0000000e);
      check("rst_valid", 32'(key_valid), 32'd0);
      check("rst_code", 32'(key_code), 32'd0);
      check("rst_data", 32'(data), 32'd0);
      rst_n = 1'b1;
      check_rotation();

      // Key 6 (row1/col2) held: one pulse, column parked on col2 while held.
      base = n_pulses;
      exp_q.push_back(4'h6);
      pressed[6] = 1'b1;
      wait_pulse(base, 200, found);
      check("k6_seen", 32'(found), 32'd1);
      for (int i = 0; i < 10; i++) begin
         repeat (SCAN_DIV) @(negedge clk);
         check("k6_col_held", 32'(kb_col), 32'hb);
      end
      check("k6_count", 32'(n_pulses - base), 32'd1);
      check("k6_data", 32'(data), 32'h0006);
      pressed = '0;
      repeat (6 * SCAN_DIV) @(negedge clk);

      // One-tick bounce on row0.
      base = n_pulses;
      wait_col_step(1, found);
      c0 = kb_col;
      ovr_val = 4'b1110;
      ovr_en  = 1'b1;
      repeat (SCAN_DIV) @(negedge clk);
      ovr_en  = 1'b0;
      ovr_val = 4'b1111;
      repeat (SCAN_DIV - 1) @(negedge clk);
      check("bounce_held", 32'(kb_col), 32'(c0));
      @(negedge clk);
      check("bounce_resume", 32'(kb_col), 32'(col_pat(2)));
      repeat (20) @(negedge clk);
      check("bounce_no_pulse", 32'(n_pulses - base), 32'd0);
      check("bounce_data", 32'(data), 32'h0006);

      // Entry of 1..5: the oldest digit falls off the top.
      for (int k = 1; k <= 5; k++) press_key(k, $urandom_range(0, 30));
      check("entry_data", 32'(data), 32'h2345);

      // Exact latency, multi-row priority, and the highest code.
      latency_test(0, 4'b1010, 4'h0);
      latency_test(3, 4'b0111, 4'hf);

      // Long hold of key A with a one-tick release glitch.
      base = n_pulses;
      exp_q.push_back(4'ha);
      pressed[10] = 1'b1;
      wait_pulse(base, 200, found);
      check("ka_seen", 32'(found), 32'd1);
      repeat (50 * SCAN_DIV) @(negedge clk);
      ovr_val = 4'b1111;
      ovr_en  = 1'b1;
      repeat (SCAN_DIV) @(negedge clk);
      ovr_en = 1'b0;
      repeat (10 * SCAN_DIV) @(negedge clk);
      check("ka_glitch_held", 32'(kb_col), 32'hb);
      pressed = '0;
      repeat (8) @(negedge clk);
      check("ka_release_wait", 32'(kb_col), 32'hb);
      repeat (6) @(negedge clk);
      check("ka_release_step", 32'(kb_col), 32'h7);
      check("ka_count", 32'(n_pulses - base), 32'd1);
      repeat (4 * SCAN_DIV) @(negedge clk);

      // Randomized single-key presses.
      for (int n = 0; n < 10; n++) begin
         press_key($urandom_range(0, 15), $urandom_range(0, 60));
         repeat ($urandom_range(0, 12)) @(negedge clk);
      end
      check("rand_queue_empty", 32'(exp_q.size()), 32'd0);

      // Asynchronous reset in the middle of a debounce.
      for (int k = 1; k <= 4; k++) press_key(k, $urandom_range(0, 20));
      check("pre_rst_data", 32'(data), 32'h1234);
      base = n_pulses;
      pressed[5] = 1'b1;
      wait_col_step(1, found);
      repeat (2 * SCAN_DIV - 1) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_col", 32'(kb_col), 32'he);
      check("async_data", 32'(data), 32'd0);
      check("async_valid", 32'(key_valid), 32'd0);
      check("async_code", 32'(key_code), 32'd0);
      check("abort_no_pulse", 32'(n_pulses - base), 32'd0);
      pressed = '0;
      exp_q.delete();
      digit_q.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      check_rotation();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
